// File: rtl/fifo_access_controller.sv
// Start-up sequencer, round-robin write arbiter and occupancy tracker for the shared pixel FIFO.
// Optional FIFO last-flag cross-check is built only when FIFO_ACCESS_CONTROLLER_SYNC_CHECK_EN is defined.
module fifo_access_controller #(
    parameter int REQUESTERS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_SIZE  = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [REQUESTERS-1:0]            req,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data,
    output logic [REQUESTERS-1:0]            grant,
    input  logic                             pop_request,
    output logic                             pop_valid,
    output logic                             fifo_enable,
    output logic                             fifo_clear,
    input  logic                             fifo_ready,
    output logic                             fifo_push,
    output logic                             fifo_pop,
    output logic [DATA_WIDTH-1:0]            fifo_in_data,
    input  logic                             fifo_pushed_last,
    input  logic                             fifo_popped_last,
    output logic [FIFO_SIZE:0]               count,
    output logic                             full,
    output logic                             empty,
    output logic                             sync_error
);

    localparam int IDXW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [FIFO_SIZE:0] L_DEPTH = (FIFO_SIZE+1)'(2**FIFO_SIZE);
    localparam logic [IDXW-1:0] L_LAST_IDX = IDXW'(REQUESTERS-1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CLEAR      = 2'd1,
        S_WAIT_READY = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_clr_cnt;
    logic [IDXW-1:0]         r_last;
    logic [FIFO_SIZE:0]      r_count;
    logic [REQUESTERS-1:0]   r_grant;
    logic                    r_fifo_push;
    logic                    r_fifo_pop;
    logic                    r_pop_valid;
    logic                    r_fifo_enable;
    logic                    r_fifo_clear;
    logic [DATA_WIDTH-1:0]   r_fifo_in_data;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_win_vld;
    logic [IDXW-1:0]         w_win_idx;
    logic                    w_push;
    logic                    w_pop;
    logic [FIFO_SIZE:0]      w_count_nxt;

    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);

    // Search begins one past the last winner so every source gets a turn.
    always_comb begin
        int j;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        j = 0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            j = int'(r_last) + k;
            if (j >= REQUESTERS) j = j - REQUESTERS;
            if (!w_win_vld && req[j]) begin
                w_win_vld = 1'b1;
                w_win_idx = IDXW'(j);
            end
        end
    end

    assign w_push = (r_state == S_RUN) && enable && !w_full  && w_win_vld;
    assign w_pop  = (r_state == S_RUN) && enable && !w_empty && pop_request;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

`ifdef FIFO_ACCESS_CONTROLLER_SYNC_CHECK_EN
    logic r_sync_error;
    assign sync_error = r_sync_error;
`else
    logic w_unused_last_flags;
    assign w_unused_last_flags = fifo_pushed_last ^ fifo_popped_last;
    assign sync_error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_clr_cnt      <= 1'b0;
            r_last         <= L_LAST_IDX;
            r_count        <= '0;
            r_grant        <= '0;
            r_fifo_push    <= 1'b0;
            r_fifo_pop     <= 1'b0;
            r_pop_valid    <= 1'b0;
            r_fifo_enable  <= 1'b0;
            r_fifo_clear   <= 1'b0;
            r_fifo_in_data <= '0;
`ifdef FIFO_ACCESS_CONTROLLER_SYNC_CHECK_EN
            r_sync_error   <= 1'b0;
`endif
        end else begin
            r_grant     <= '0;
            r_fifo_push <= 1'b0;
            r_fifo_pop  <= 1'b0;
            r_pop_valid <= 1'b0;
            if (r_state != S_IDLE && !enable) begin
                // Abort: strobes are dropped, occupancy is kept until the next clear.
                r_state       <= S_IDLE;
                r_fifo_enable <= 1'b0;
                r_fifo_clear  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_state       <= S_CLEAR;
                            r_clr_cnt     <= 1'b0;
                            r_fifo_enable <= 1'b1;
                            r_fifo_clear  <= 1'b1;
                            r_count       <= '0;
                            r_last        <= L_LAST_IDX;
`ifdef FIFO_ACCESS_CONTROLLER_SYNC_CHECK_EN
                            r_sync_error  <= 1'b0;
`endif
                        end
                    end
                    S_CLEAR: begin
                        if (r_clr_cnt) begin
                            r_state      <= S_WAIT_READY;
                            r_fifo_clear <= 1'b0;
                        end else begin
                            r_clr_cnt <= 1'b1;
                        end
                    end
                    S_WAIT_READY: begin
                        if (fifo_ready) r_state <= S_RUN;
                    end
                    S_RUN: begin
                        r_pop_valid <= r_fifo_pop;
                        r_count     <= w_count_nxt;
                        if (w_push) begin
                            r_grant        <= REQUESTERS'(1) << w_win_idx;
                            r_fifo_push    <= 1'b1;
                            r_fifo_in_data <= req_data[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
                            r_last         <= w_win_idx;
                        end
                        r_fifo_pop <= w_pop;
`ifdef FIFO_ACCESS_CONTROLLER_SYNC_CHECK_EN
                        // Last-flags are sampled one cycle after the strobe, against the updated count.
                        if ((r_fifo_push && fifo_pushed_last && r_count != L_DEPTH) ||
                            (r_fifo_pop  && fifo_popped_last && r_count != '0))
                            r_sync_error <= 1'b1;
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign grant        = r_grant;
    assign fifo_push    = r_fifo_push;
    assign fifo_pop     = r_fifo_pop;
    assign pop_valid    = r_pop_valid;
    assign fifo_enable  = r_fifo_enable;
    assign fifo_clear   = r_fifo_clear;
    assign fifo_in_data = r_fifo_in_data;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;

endmodule

// File: tb/tb_fifo_access_controller.sv
// Directed bench for fifo_access_controller: start-up, round-robin, full/empty limits, abort and sync flag.
module tb_fifo_access_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic        pop_request;
    logic        pop_valid;
    logic        fifo_enable;
    logic        fifo_clear;
    logic        fifo_ready;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_in_data;
    logic        fifo_pushed_last;
    logic        fifo_popped_last;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        sync_error;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_access_controller dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req(req), .req_data(req_data), .grant(grant),
        .pop_request(pop_request), .pop_valid(pop_valid),
        .fifo_enable(fifo_enable), .fifo_clear(fifo_clear), .fifo_ready(fifo_ready),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_in_data(fifo_in_data),
        .fifo_pushed_last(fifo_pushed_last), .fifo_popped_last(fifo_popped_last),
        .count(count), .full(full), .empty(empty), .sync_error(sync_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; req = '0; pop_request = 1'b0; fifo_ready = 1'b0;
        fifo_pushed_last = 1'b0; fifo_popped_last = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        #23;
        n_tests++; if (fifo_enable !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_enable got %b want 0", fifo_enable); end
        n_tests++; if (fifo_clear !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_clear got %b want 0", fifo_clear); end
        n_tests++; if (grant !== 4'h0) begin n_fail++; $display("FAIL reset_grant got %h want 0", grant); end
        n_tests++; if ({fifo_push, fifo_pop, pop_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {fifo_push, fifo_pop, pop_valid}); end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if ({empty, full} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full got %b want 10", {empty, full}); end
        n_tests++; if (fifo_in_data !== 8'h00) begin n_fail++; $display("FAIL reset_in_data got %h want 00", fifo_in_data); end
        n_tests++; if (sync_error !== 1'b0) begin n_fail++; $display("FAIL reset_sync_error got %b want 0", sync_error); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_startup();
        int clr_hi;
        clr_hi = 0;
        enable = 1'b1;
        req = 4'hF;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (fifo_clear) clr_hi++;
            if (i == 0) begin
                n_tests++; if (fifo_enable !== 1'b1) begin n_fail++; $display("FAIL start_fifo_enable got %b want 1", fifo_enable); end
                n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL start_count got %0d want 0", count); end
            end
        end
        n_tests++; if (clr_hi != 2) begin n_fail++; $display("FAIL start_clear_cycles got %0d want 2", clr_hi); end
        n_tests++; if (grant !== 4'h0) begin n_fail++; $display("FAIL start_wait_no_grant got %h want 0", grant); end
        fifo_ready = 1'b1;
        cyc();
        n_tests++; if ({grant, fifo_push} !== 5'b0) begin n_fail++; $display("FAIL start_run_entry got %b want 00000", {grant, fifo_push}); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] ed;
        for (int i = 0; i < 8; i++) begin
            cyc();
            eg = 4'b0001 << (i % 4);
            ed = 8'h10 + 8'(i % 4);
            n_tests++; if (grant !== eg) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, grant, eg); end
            n_tests++; if (fifo_push !== 1'b1 || fifo_in_data !== ed) begin n_fail++; $display("FAIL rr_push[%0d] got %b/%h want 1/%h", i, fifo_push, fifo_in_data, ed); end
            n_tests++; if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL rr_count[%0d] got %0d want %0d", i, count, i + 1); end
        end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL rr_full got %b want 1", full); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++; if (fifo_push !== 1'b0 || count !== 4'd8) begin n_fail++; $display("FAIL rr_hold_full[%0d] got push %b count %0d want 0/8", i, fifo_push, count); end
        end
    endtask

    task automatic test_full_pop();
        pop_request = 1'b1;
        req = 4'b0100;
        cyc();
        n_tests++; if ({fifo_pop, fifo_push} !== 2'b10 || count !== 4'd7) begin n_fail++; $display("FAIL fullpop_first got pop/push %b count %0d want 10/7", {fifo_pop, fifo_push}, count); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++; if ({fifo_pop, fifo_push, pop_valid} !== 3'b111 || grant !== 4'b0100) begin n_fail++; $display("FAIL fullpop_both[%0d] got %b grant %b want 111 0100", i, {fifo_pop, fifo_push, pop_valid}, grant); end
            n_tests++; if (count !== 4'd7 || fifo_in_data !== 8'h12) begin n_fail++; $display("FAIL fullpop_count[%0d] got %0d/%h want 7/12", i, count, fifo_in_data); end
        end
        req = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            cyc();
            n_tests++; if (fifo_pop !== 1'b1 || count !== 4'(6 - i)) begin n_fail++; $display("FAIL drain[%0d] got pop %b count %0d want 1/%0d", i, fifo_pop, count, 6 - i); end
        end
        pop_request = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
    endtask

    task automatic test_empty_pop();
        pop_request = 1'b1;
        req = 4'b0010;
        cyc();
        n_tests++; if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL empty_no_pop got %b want 0", fifo_pop); end
        n_tests++; if (grant !== 4'b0010 || fifo_in_data !== 8'h11) begin n_fail++; $display("FAIL empty_push got %b/%h want 0010/11", grant, fifo_in_data); end
        n_tests++; if (count !== 4'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL empty_count got %0d/%b want 1/0", count, empty); end
        req = 4'b0000;
        pop_request = 1'b0;
    endtask

    task automatic test_disable();
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++; if (grant !== 4'b0001 || count !== 4'(2 + i)) begin n_fail++; $display("FAIL dis_fill[%0d] got %b/%0d want 0001/%0d", i, grant, count, 2 + i); end
        end
        req = 4'b0000;
        enable = 1'b0;
        cyc();
        n_tests++; if (fifo_enable !== 1'b0 || fifo_push !== 1'b0) begin n_fail++; $display("FAIL dis_idle got en %b push %b want 0/0", fifo_enable, fifo_push); end
        cyc();
        n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL dis_count_held got %0d want 5", count); end
        enable = 1'b1;
        req = 4'hF;
        cyc();
        n_tests++; if (fifo_clear !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL reen_clear got clr %b count %0d empty %b want 1/0/1", fifo_clear, count, empty); end
        cyc();
        n_tests++; if (fifo_clear !== 1'b1) begin n_fail++; $display("FAIL reen_clear2 got %b want 1", fifo_clear); end
        cyc();
        n_tests++; if (fifo_clear !== 1'b0 || grant !== 4'h0) begin n_fail++; $display("FAIL reen_wait got clr %b grant %b want 0/0000", fifo_clear, grant); end
        cyc();
        n_tests++; if (grant !== 4'h0) begin n_fail++; $display("FAIL reen_run_entry got %b want 0000", grant); end
        cyc();
        n_tests++; if (grant !== 4'b0001 || count !== 4'd1) begin n_fail++; $display("FAIL reen_first_grant got %b/%0d want 0001/1", grant, count); end
    endtask

    task automatic test_sync();
        logic exp;
`ifdef FIFO_ACCESS_CONTROLLER_SYNC_CHECK_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        cyc();
        n_tests++; if (grant !== 4'b0010 || count !== 4'd2) begin n_fail++; $display("FAIL sync_push1 got %b/%0d want 0010/2", grant, count); end
        cyc();
        n_tests++; if (grant !== 4'b0100 || count !== 4'd3) begin n_fail++; $display("FAIL sync_push2 got %b/%0d want 0100/3", grant, count); end
        req = 4'b0000;
        fifo_pushed_last = 1'b1;
        cyc();
        n_tests++; if (sync_error !== exp) begin n_fail++; $display("FAIL sync_set got %b want %b", sync_error, exp); end
        fifo_pushed_last = 1'b0;
        cyc();
        cyc();
        n_tests++; if (sync_error !== exp) begin n_fail++; $display("FAIL sync_sticky got %b want %b", sync_error, exp); end
        #2 reset = 1'b1;
        #2;
        n_tests++; if (sync_error !== 1'b0 || count !== 4'd0 || fifo_enable !== 1'b0) begin n_fail++; $display("FAIL sync_async_reset got %b/%0d/%b want 0/0/0", sync_error, count, fifo_enable); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_round_robin();
        test_full_pop();
        test_empty_pop();
        test_disable();
        test_sync();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_access_controller.md
# fifo_access_controller

Single-clock sequencer and arbiter for the shared pixel FIFO in the image-processing pipeline. Runs the FIFO clear/ready start-up sequence and arbitrates up to four pixel sources round-robin onto the FIFO write port. Serves a single consumer on the read side and keeps an occupancy count that drives full/empty back-pressure. Sits directly in front of one `fifo` instance and generates its enable, clear, push and pop strobes.

## Interface
Parameters:
- `REQUESTERS`, default 4, number of write requesters; legal range 1..4.
- `DATA_WIDTH`, default 8, pixel width in bits.
- `FIFO_SIZE`, default 3, log2 of FIFO depth; DEPTH = 2**FIFO_SIZE, so 8 entries at the default.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run request.
- `req` in REQUESTERS: per-source write request; held until granted.
- `req_data` in REQUESTERS*DATA_WIDTH: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant` out REQUESTERS: one-hot, one-cycle acceptance pulse.
- `pop_request` in 1: consumer read request.
- `pop_valid` out 1: one-cycle pulse when FIFO `out_data` is valid.
- `fifo_enable` out 1, `fifo_clear` out 1: drive the FIFO enable and clear inputs.
- `fifo_ready` in 1: FIFO ready flag.
- `fifo_push` out 1, `fifo_pop` out 1: one-cycle strobes to the FIFO push and pop clocks.
- `fifo_in_data` out DATA_WIDTH: registered write data.
- `fifo_pushed_last` in 1, `fifo_popped_last` in 1: FIFO last-flags.
- `count` out FIFO_SIZE+1: occupancy, 0..DEPTH.
- `full` out 1, `empty` out 1: `full` = (count==DEPTH); `empty` = (count==0).
- `sync_error` out 1: sticky flag; see Configuration.

## Operation
- State machine with states IDLE, CLEAR, WAIT_READY and RUN.
  - IDLE: `fifo_enable`=0. `enable`=1 moves to CLEAR.
  - CLEAR: `fifo_enable`=1 and `fifo_clear`=1 for exactly 2 cycles. `count` is reset to 0. Then moves to WAIT_READY.
  - WAIT_READY: `fifo_enable`=1. Waits for `fifo_ready`=1, then moves to RUN.
  - RUN: arbitration and pops are active.
- `enable`=0 in any non-IDLE state returns to IDLE on the next edge. Any pending strobe is dropped. `count` is held until the next CLEAR.
- Push arbitration (RUN, `full`=0):
  - Round-robin search starts at the index after the last granted source.
  - After reset or CLEAR, the last granted index is REQUESTERS-1, so source 0 has first priority.
  - The winner gets a `grant` pulse. `fifo_push` pulses high with its data on `fifo_in_data`.
- Pop (RUN, `pop_request`=1, `empty`=0): `fifo_pop` pulses for one cycle; `pop_valid` pulses on the following cycle.
- Count arithmetic:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
- Count never wraps:
  - No push is issued when `full`=1, including when a pop happens in the same cycle.
  - No pop is issued when `empty`=1, including when a push happens in the same cycle.

## Timing
- Reset values: state IDLE, all outputs 0 except `empty`=1. `grant`=0, `count`=0, `fifo_in_data`=0.
- Grant latency:
  - `req` is sampled at edge N.
  - `grant`, `fifo_push` and `fifo_in_data` are valid during the cycle after edge N.
  - `count` updates on that same edge N.
- Back-pressure: `full` and `empty` are combinational from `count`, so they already include the push or pop being strobed.
- Throughput: at most one push and one pop per cycle. With continuous requests, sources are granted back-to-back in rotation.
- A requester deasserts `req`, or presents new data, only after seeing `grant`.
- Pop latency: `pop_request` at edge N, `fifo_pop` high after edge N, `pop_valid` high after edge N+1.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. The FIFO contents are re-cleared by the next CLEAR sequence.

## Configuration
- Macro `FIFO_ACCESS_CONTROLLER_SYNC_CHECK_EN`.
- Defined: in RUN, `sync_error` sets and stays set until reset or CLEAR when either mismatch occurs:
  - `fifo_pushed_last`=1 while `count`≠DEPTH, one cycle after a push.
  - `fifo_popped_last`=1 while `count`≠0, one cycle after a pop.
- Undefined: no check logic is built, `sync_error` is tied to 0, and both last-flags are ignored.

## Test plan
- Reset, then `enable`=1 and `fifo_ready` raised 3 cycles after CLEAR ends -> `fifo_clear` high exactly 2 cycles; RUN entered one cycle after `fifo_ready`.
- All 4 `req` held high, data 0x10..0x13, no pops -> grants in order 0,1,2,3,0,1,2,3. After 8 pushes, `full`=1 and `count`=8; no further `fifo_push` occurs.
- FIFO full with `pop_request` and `req[2]` both held -> pop only in the first cycle (`count` 7), then push and pop alternate or coincide with `count` staying between 7 and 8, never exceeding 8.
- `pop_request` on an empty FIFO while `req[1]` is asserted -> no `fifo_pop`, one push of req_data[1]; `count`=1 and `empty`=0 on the next cycle.
- `enable` dropped in RUN with `count`=5 -> IDLE on the next edge, `fifo_enable`=0. Re-enabling runs CLEAR and `count` returns to 0.
- With the macro defined, `fifo_pushed_last` forced high at `count`=3 -> `sync_error`=1 and it stays 1 until reset.
